// File: rtl/ext_tran_bridge_if.sv
// Wishbone classic bus bundle between the bridge and its slave.
// Names keep the bridge-side direction suffixes.
interface ext_tran_bridge_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/ext_tran_bridge.sv
// Single-transaction bridge to a Wishbone master port.
// Checks alignment, runs one bus cycle with timeout, holds result.
module ext_tran_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ext_tran_addr_i,
  input  logic [31:0] ext_tran_data_i,
  input  logic [1:0]  ext_tran_size_i,
  input  logic        ext_tran_start_i,
  input  logic        ext_tran_write_i,
  input  logic        ext_tran_clear_i,
  output logic [31:0] ext_tran_data_o,
  output logic        ext_tran_ready_o,
  output logic        ext_tran_err_o,
  output logic        ext_tran_timeout_o,
  ext_tran_bridge_if.master wb
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  lo_q;
  logic [1:0]  size_q;
  logic [31:0] adr_q;
  logic [31:0] wdat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        cyc_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;
  logic        to_q;

  logic        legal_d;
  logic [3:0]  sel_d;
  logic [31:0] wdat_d;
  logic [31:0] lane_d;
  logic [31:0] rdat_d;

  // Legality, byte lanes and replicated write data for a new request
  always_comb begin
    legal_d = 1'b1;
    sel_d   = 4'b0000;
    wdat_d  = ext_tran_data_i;
    unique case (ext_tran_size_i)
      2'd0: begin
        sel_d  = 4'b0001 << ext_tran_addr_i[1:0];
        wdat_d = {4{ext_tran_data_i[7:0]}};
      end
      2'd1: begin
        legal_d = ~ext_tran_addr_i[0];
        sel_d   = ext_tran_addr_i[1] ? 4'b1100 : 4'b0011;
        wdat_d  = {2{ext_tran_data_i[15:0]}};
      end
      2'd2: begin
        legal_d = (ext_tran_addr_i[1:0] == 2'b00);
        sel_d   = 4'b1111;
      end
      default: legal_d = 1'b0;
    endcase
  end

  // Right-align and zero-extend the selected read lanes
  always_comb begin
    lane_d = wb.wb_dat_i >> {lo_q, 3'b000};
    rdat_d = wb.wb_dat_i;
    unique case (size_q)
      2'd0: rdat_d = {24'h0, lane_d[7:0]};
      2'd1: rdat_d = lo_q[1] ? {16'h0, wb.wb_dat_i[31:16]}
                             : {16'h0, wb.wb_dat_i[15:0]};
      default: rdat_d = wb.wb_dat_i;
    endcase
  end

  // Transaction FSM with registered bus and result outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'h0;
      lo_q    <= 2'b00;
      size_q  <= 2'b00;
      adr_q   <= 32'h0;
      wdat_q  <= 32'h0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ext_tran_start_i) begin
            lo_q   <= ext_tran_addr_i[1:0];
            size_q <= ext_tran_size_i;
            if (legal_d) begin
              state_q <= BUS;
              cnt_q   <= 8'h0;
              adr_q   <= {ext_tran_addr_i[31:2], 2'b00};
              wdat_q  <= wdat_d;
              sel_q   <= sel_d;
              we_q    <= ext_tran_write_i;
              cyc_q   <= 1'b1;
            end else begin
              state_q <= DONE;
              rdata_q <= 32'h0;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              to_q    <= 1'b0;
            end
          end
        end
        BUS: begin
          if (wb.wb_err_i || wb.wb_ack_i ||
              cnt_q == TO_LAST) begin
            state_q <= DONE;
            cyc_q   <= 1'b0;
            adr_q   <= 32'h0;
            wdat_q  <= 32'h0;
            sel_q   <= 4'h0;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            if (wb.wb_err_i) begin
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else if (wb.wb_ack_i) begin
              err_q   <= 1'b0;
              rdata_q <= we_q ? 32'h0 : rdat_d;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              err_q   <= 1'b1;
              to_q    <= 1'b1;
              rdata_q <= 32'h0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          if (ext_tran_clear_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = wdat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;

  assign ext_tran_data_o    = rdata_q;
  assign ext_tran_ready_o   = ready_q;
  assign ext_tran_err_o     = err_q;
  assign ext_tran_timeout_o = to_q;

endmodule

// File: doc/ext_tran_bridge.md
EXT_TRAN_BRIDGE -- requirements
Module: ext_tran_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of bus cycles waited for ack/err before abort (range 1..255).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ext_tran_addr_i, input, 32 bits: transaction byte address.
REQ-005 SHALL have port ext_tran_data_i, input, 32 bits: write data, right-aligned.
REQ-006 SHALL have port ext_tran_size_i, input, 2 bits: 0 = byte, 1 = halfword, 2 = word, 3 = reserved.
REQ-007 SHALL have port ext_tran_start_i, input, 1 bit: start request, sampled each cycle.
REQ-008 SHALL have port ext_tran_write_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port ext_tran_clear_i, input, 1 bit: acknowledges the completed result.
REQ-010 SHALL have port ext_tran_data_o, output, 32 bits: read data, right-aligned, zero-extended.
REQ-011 SHALL have port ext_tran_ready_o, output, 1 bit: result valid (sticky).
REQ-012 SHALL have port ext_tran_err_o, output, 1 bit: result is an error (sticky, qualified by ready).
REQ-013 SHALL have port ext_tran_timeout_o, output, 1 bit: the error was caused by timeout.
REQ-014 SHALL have Wishbone master ports: wb_adr_o out 32, wb_dat_o out 32, wb_sel_o out 4, wb_we_o out 1, wb_cyc_o out 1, wb_stb_o out 1, wb_dat_i in 32, wb_ack_i in 1, wb_err_i in 1.

Function
REQ-015 SHALL implement FSM states IDLE, BUS, DONE.
REQ-016 In IDLE, ext_tran_start_i=1 SHALL capture addr, data, size and write into internal registers in the same edge.
REQ-017 Legality check at start: size 3, size 1 with addr[0]=1, or size 2 with addr[1:0]!=0 SHALL go directly to DONE with err=1, timeout=0, data_o=0, and no bus cycle.
REQ-018 A legal start SHALL go to BUS; wb_cyc_o and wb_stb_o SHALL be 1 from the cycle after start until the cycle after ack, err or timeout is sampled.
REQ-019 In BUS: wb_adr_o = {addr[31:2],2'b00} and wb_we_o = write; all bus outputs SHALL be stable for the whole cycle.
REQ-020 wb_sel_o SHALL be: byte = 4'b0001<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
REQ-021 wb_dat_o SHALL be: byte data replicated in all 4 lanes; half data replicated in both halves; word data as-is.
REQ-022 On wb_ack_i=1 in BUS, the FSM SHALL go to DONE with err=0.
REQ-023 On an acked read, ext_tran_data_o SHALL be loaded with the selected lane(s) of wb_dat_i, shifted to bit 0 and zero-extended.
REQ-024 On an acked write, ext_tran_data_o SHALL be loaded with 0.
REQ-025 On wb_err_i=1 in BUS, the FSM SHALL go to DONE with err=1 and data_o=0; if ack and err are both 1 in the same cycle, err SHALL win.
REQ-026 An 8-bit wait counter SHALL clear on BUS entry and increment each BUS cycle without ack/err.
REQ-027 When the wait counter reaches TIMEOUT_CYCLES, the FSM SHALL drop cyc/stb, go to DONE with err=1, timeout=1 and data_o=0.
REQ-028 In DONE, ext_tran_ready_o SHALL be 1 and the result outputs SHALL be held until ext_tran_clear_i=1.
REQ-029 ext_tran_clear_i=1 in DONE SHALL return the FSM to IDLE and clear ready, err and timeout on the next edge; ext_tran_data_o SHALL keep its value.
REQ-030 ext_tran_start_i SHALL be ignored in BUS and DONE, including a start asserted in the same cycle as clear.
REQ-031 ext_tran_clear_i SHALL be ignored in IDLE and BUS; a bus cycle SHALL NOT be abortable except by reset.
REQ-032 Latency: a legal start at edge N SHALL assert cyc at N+1; an ack sampled at edge M SHALL give ready=1 and cyc=0 at M+1.
REQ-033 The minimum legal round trip SHALL be 2 cycles from start to ready.

Reset
REQ-034 rst_i=1 SHALL force IDLE, clear the wait counter and drive all outputs to 0 on the next edge, including mid-BUS (cyc dropped immediately, pending ack discarded).
REQ-035 During reset, start, clear and all bus inputs SHALL be ignored.

Verification
REQ-036 Word read: addr=0x100, size=2, start -> cyc/stb=1, sel=1111, adr=0x100; slave ack with 0xDEADBEEF -> ready=1, data_o=0xDEADBEEF, err=0; clear -> ready=0.
REQ-037 Byte write: addr=0x203, data=0xA5, size=0, write=1 -> sel=1000, dat_o=0xA5A5A5A5, we=1; ack -> ready=1, data_o=0.
REQ-038 Halfword read at addr=0x12 with wb_dat_i=0x1234ABCD -> sel=1100, data_o=0x00001234.
REQ-039 Misaligned start: size=2, addr=0x5 -> cyc never asserted; ready=1, err=1 one cycle after start. Same result for size=3.
REQ-040 Timeout with TIMEOUT_CYCLES=4, no ack -> cyc drops after 4 BUS cycles; ready=err=timeout=1. Separately, ack+err in the same cycle -> err=1.
REQ-041 Reset asserted in the 2nd BUS cycle -> next edge cyc=0, ready=0; an ack arriving afterwards has no effect; a start in the same cycle as clear in DONE is not executed.
